// File: rtl/rtype_pkg.sv
// rtype_pkg: shared funct codes, FSM states and instruction field positions
package rtype_pkg;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5,  FN_LO = 0;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
  function automatic logic is_legal(input logic [31:0] w);
    logic [5:0] f;
    f = w[FN_HI:FN_LO];
    return (w[OP_HI:OP_LO] == 6'd0) &&
           (f == F_ADD || f == F_SUB || f == F_SRL || f == F_AND || f == F_OR || f == F_SLT);
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 registers, three combinational read ports, one write port, r0 hardwired to zero
module regfile #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] mem [N];
  assign rs_data  = (rs_addr  == 5'd0) ? 32'd0 : mem[rs_addr];
  assign rt_data  = (rt_addr  == 5'd0) ? 32'd0 : mem[rt_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : mem[dbg_addr];
  // storage: cleared on reset, writes to r0 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end
endmodule

// File: rtl/rtype_seq.sv
// rtype_seq: four-state sequencer executing R-type add/sub/srl/and/or/slt on a 32-entry regfile
module rtype_seq
  import rtype_pkg::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        done,
  output logic [4:0]  done_rd,
  output logic [31:0] done_data,
  output logic        illegal,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);
  state_t state, next;
  logic [4:0]  ir_rs, ir_rt, ir_rd, ir_sh;
  logic [5:0]  ir_fn;
  logic [31:0] a, b, alu, rs_data, rt_data, wd;
  logic        accept, we;
  logic [4:0]  wa;

  assign accept = instr_valid && state == S_IDLE;

  regfile #(.N(REG_COUNT)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(ir_rs), .rt_addr(ir_rt), .dbg_addr(dbg_addr),
    .rs_data(rs_data), .rt_data(rt_data), .dbg_data(dbg_rdata),
    .we(we), .wa(wa), .wd(wd)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  // next state, handshake and write-port arbitration (WB wins, debug only in IDLE)
  always_comb begin
    next        = state;
    instr_ready = 1'b0;
    we          = 1'b0;
    wa          = dbg_addr;
    wd          = dbg_wdata;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        we          = dbg_we;
        next        = (accept && is_legal(instr)) ? S_READ : S_IDLE;
      end
      S_READ: next = S_EXEC;
      S_EXEC: next = S_WB;
      S_WB: begin
        we   = 1'b1;
        wa   = done_rd;
        wd   = done_data;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // ALU on the latched operands
  always_comb begin
    alu = (ir_fn == F_ADD) ? a + b :
          (ir_fn == F_SUB) ? a - b :
          (ir_fn == F_SRL) ? b >> ir_sh :
          (ir_fn == F_AND) ? a & b :
          (ir_fn == F_OR)  ? a | b :
          {31'd0, $signed(a) < $signed(b)};
  end

  // datapath: latch fields on accept, operands in READ, result in EXEC; done fires in WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ir_rs, ir_rt, ir_rd, ir_sh, ir_fn} <= '0;
      a         <= '0;
      b         <= '0;
      done      <= 1'b0;
      done_rd   <= '0;
      done_data <= '0;
      illegal   <= 1'b0;
    end else begin
      if (accept) begin
        ir_rs <= instr[RS_HI:RS_LO];
        ir_rt <= instr[RT_HI:RT_LO];
        ir_rd <= instr[RD_HI:RD_LO];
        ir_sh <= instr[SH_HI:SH_LO];
        ir_fn <= instr[FN_HI:FN_LO];
      end
      illegal <= accept && !is_legal(instr);
      done    <= state == S_EXEC;
      if (state == S_READ) begin
        a <= rs_data;
        b <= rt_data;
      end
      if (state == S_EXEC) begin
        done_rd   <= ir_rd;
        done_data <= alu;
      end
    end
  end
endmodule

// File: tb/tb_rtype_seq.sv
// tb_rtype_seq: directed self-checking bench for rtype_seq
module tb_rtype_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        done;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        illegal;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic [31:0] exp_reg [32];
  int tests = 0;
  int fails = 0;

  rtype_seq #(.REG_COUNT(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .done_rd(done_rd), .done_data(done_data),
    .illegal(illegal), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic dbg_write(input logic [4:0] ad, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = ad; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    if (ad != 5'd0) exp_reg[ad] = d;
  endtask

  // issue one legal instruction from IDLE and follow it through READ/EXEC/WB
  task automatic run(input logic [31:0] w, input logic [4:0] rd, input logic [31:0] want, input string name);
    instr = w; instr_valid = 1'b1;
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL %s ready: got %b want 1", name, instr_ready); end
    @(posedge clk); #1;
    instr_valid = 1'b0; dbg_we = 1'b0;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s done_read: got %b want 0", name, done); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s done_exec: got %b want 0", name, done); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL %s done_wb: got %b want 1", name, done); end
    tests++; if (done_rd !== rd) begin fails++; $display("FAIL %s done_rd: got %0d want %0d", name, done_rd, rd); end
    tests++; if (done_data !== want) begin fails++; $display("FAIL %s done_data: got %h want %h", name, done_data, want); end
    if (rd != 5'd0) exp_reg[rd] = want;
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || instr_ready !== 1'b1) begin fails++; $display("FAIL %s after_wb done/ready: got %b/%b want 0/1", name, done, instr_ready); end
    tests++; if (done_data !== want) begin fails++; $display("FAIL %s hold: got %h want %h", name, done_data, want); end
    dbg_addr = rd; #1;
    tests++; if (dbg_rdata !== exp_reg[rd]) begin fails++; $display("FAIL %s dbg_rd: got %h want %h", name, dbg_rdata, exp_reg[rd]); end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 32; i++) exp_reg[i] = '0;
    #2;
    tests++; if (done !== 1'b0 || illegal !== 1'b0) begin fails++; $display("FAIL reset done/illegal: got %b/%b want 0/0", done, illegal); end
    tests++; if (done_rd !== 5'd0 || done_data !== 32'd0) begin fails++; $display("FAIL reset done_rd/data: got %0d/%h want 0/0", done_rd, done_data); end
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset ready: got %b want 1", instr_ready); end
    dbg_addr = 5'd5; #1;
    tests++; if (dbg_rdata !== 32'd0) begin fails++; $display("FAIL reset r5: got %h want 0", dbg_rdata); end
  endtask

  task automatic test_add;
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd7);
    run(32'h0022_1820, 5'd3, 32'd12, "add");
  endtask

  task automatic test_sub_slt;
    dbg_write(5'd1, 32'd0);
    dbg_write(5'd2, 32'd1);
    run(enc(5'd1, 5'd2, 5'd4, 5'd0, 6'b100010), 5'd4, 32'hFFFF_FFFF, "sub");
    run(enc(5'd1, 5'd2, 5'd5, 5'd0, 6'b101010), 5'd5, 32'd1, "slt_lt");
    run(enc(5'd2, 5'd1, 5'd5, 5'd0, 6'b101010), 5'd5, 32'd0, "slt_ge");
    run(enc(5'd4, 5'd2, 5'd5, 5'd0, 6'b101010), 5'd5, 32'd1, "slt_neg");
  endtask

  task automatic test_logic;
    dbg_write(5'd8, 32'h0000_FF0F);
    dbg_write(5'd9, 32'h00F0_F0F0);
    run(enc(5'd8, 5'd9, 5'd10, 5'd0, 6'b100100), 5'd10, 32'h0000_F000, "and");
    run(enc(5'd8, 5'd9, 5'd10, 5'd0, 6'b100101), 5'd10, 32'h00F0_FFFF, "or");
  endtask

  task automatic test_srl;
    dbg_write(5'd2, 32'h8000_0000);
    run(enc(5'd0, 5'd2, 5'd6, 5'd31, 6'b000010), 5'd6, 32'd1, "srl31");
    run(enc(5'd0, 5'd2, 5'd6, 5'd4, 6'b000010), 5'd6, 32'h0800_0000, "srl4");
    run(enc(5'd1, 5'd2, 5'd0, 5'd0, 6'b100000), 5'd0, 32'h8000_0000, "add_r0");
  endtask

  task automatic test_illegal;
    logic [31:0] words [2];
    words[0] = {6'h23, 5'd1, 5'd2, 5'd11, 5'd0, 6'h20};
    words[1] = enc(5'd1, 5'd2, 5'd11, 5'd0, 6'h18);
    for (int k = 0; k < 2; k++) begin
      instr = words[k]; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL illegal%0d pulse: got %b want 1", k, illegal); end
      tests++; if (instr_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL illegal%0d ready/done: got %b/%b want 1/0", k, instr_ready, done); end
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        tests++; if (illegal !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL illegal%0d tail%0d illegal/done: got %b/%b want 0/0", k, c, illegal, done); end
      end
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      tests++; if (dbg_rdata !== exp_reg[i]) begin fails++; $display("FAIL illegal reg%0d: got %h want %h", i, dbg_rdata, exp_reg[i]); end
    end
  endtask

  task automatic test_dbg_busy;
    dbg_write(5'd1, 32'd10);
    dbg_write(5'd2, 32'd20);
    instr = enc(5'd1, 5'd2, 5'd14, 5'd0, 6'b100000); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'd9;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || done_data !== 32'd30) begin fails++; $display("FAIL busy done/data: got %b/%h want 1/1e", done, done_data); end
    @(posedge clk); #1;
    dbg_we = 1'b0;
    exp_reg[14] = 32'd30;
    #1;
    tests++; if (dbg_rdata !== exp_reg[7]) begin fails++; $display("FAIL busy r7: got %h want %h", dbg_rdata, exp_reg[7]); end
    dbg_addr = 5'd14; #1;
    tests++; if (dbg_rdata !== 32'd30) begin fails++; $display("FAIL busy r14: got %h want 1e", dbg_rdata); end
  endtask

  task automatic test_same_cycle;
    dbg_we = 1'b1; dbg_addr = 5'd1; dbg_wdata = 32'd3;
    exp_reg[1] = 32'd3;
    run(enc(5'd1, 5'd2, 5'd12, 5'd0, 6'b100000), 5'd12, 32'd23, "same_cycle");
  endtask

  task automatic test_back_to_back;
    run(enc(5'd12, 5'd1, 5'd13, 5'd0, 6'b100010), 5'd13, 32'd20, "b2b_0");
    run(enc(5'd13, 5'd12, 5'd13, 5'd0, 6'b100000), 5'd13, 32'd43, "b2b_1");
  endtask

  task automatic test_reset_mid;
    instr = enc(5'd1, 5'd2, 5'd15, 5'd0, 6'b100000); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #2;
    for (int i = 0; i < 32; i++) exp_reg[i] = '0;
    tests++; if (done !== 1'b0 || instr_ready !== 1'b1) begin fails++; $display("FAIL rst_mid in_reset done/ready: got %b/%b want 0/1", done, instr_ready); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests++; if (done !== 1'b0 || instr_ready !== 1'b1) begin fails++; $display("FAIL rst_mid c%0d done/ready: got %b/%b want 0/1", c, done, instr_ready); end
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      tests++; if (dbg_rdata !== 32'd0) begin fails++; $display("FAIL rst_mid reg%0d: got %h want 0", i, dbg_rdata); end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_slt;
    test_logic;
    test_srl;
    test_illegal;
    test_dbg_busy;
    test_same_cycle;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rtype_seq.md
RTYPE_SEQ -- requirements
Module: rtype_seq

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of architectural registers (fixed 32; 5-bit addresses).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 instr_valid  in  1  instruction word offered.
REQ-005 instr_ready  out  1  block can accept an instruction.
REQ-006 instr  in  32  R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-007 done  out  1  one-cycle pulse, writeback performed.
REQ-008 done_rd  out  5  destination of completed instruction.
REQ-009 done_data  out  32  result of completed instruction.
REQ-010 illegal  out  1  one-cycle pulse, instruction rejected.
REQ-011 dbg_we  in  1  debug register write strobe.
REQ-012 dbg_addr  in  5  debug read/write address.
REQ-013 dbg_wdata  in  32  debug write data.
REQ-014 dbg_rdata  out  32  combinational read of register dbg_addr.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> EXEC -> WB -> IDLE, one state per cycle.
REQ-016 instr_ready SHALL be 1 only in IDLE; accept on instr_valid && instr_ready; instruction latched.
REQ-017 Legal iff op==0 and funct in {100000 add, 100010 sub, 000010 srl, 100100 and, 100101 or, 101010 slt}.
REQ-018 Illegal accepted word: illegal pulses in the cycle after acceptance, FSM returns to IDLE, no register write, no done.
REQ-019 READ SHALL latch regfile[rs] and regfile[rt]; EXEC SHALL register the result.
REQ-020 add/sub SHALL wrap modulo 2^32; no overflow flag.
REQ-021 srl SHALL produce rt >> shamt, logical, zero fill.
REQ-022 slt SHALL produce 32'd1 if rs < rt (signed), else 32'd0.
REQ-023 WB SHALL write result to rd, except rd==0 which is discarded; done pulses in the WB cycle with done_rd/done_data valid.
REQ-024 Latency: acceptance at edge N -> done high in cycle N+3; peak throughput one instruction per 4 cycles.
REQ-025 Register 0 SHALL read as zero on every port regardless of writes.
REQ-026 dbg_we SHALL be honoured only in IDLE; ignored in READ/EXEC/WB.
REQ-027 dbg write and instruction acceptance in the same IDLE cycle SHALL both occur; READ sees the debug-written value.
REQ-028 done_rd/done_data SHALL hold last completed values between pulses.

Reset
REQ-029 rst_n low SHALL force FSM to IDLE and clear all 32 registers, done, illegal, done_rd, done_data to 0 asynchronously.
REQ-030 Reset during READ/EXEC/WB SHALL abandon the instruction with no writeback and no done.
REQ-031 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package rtype_pkg SHALL hold funct codes, FSM state enum, and instruction field bit positions.
REQ-033 Register storage SHALL be a sub-module regfile: 32x32, three combinational read ports (rs, rt, dbg), one synchronous write port, r0 zero.
REQ-034 Write port arbitration SHALL be in rtype_seq: WB write, else dbg write in IDLE.

Verification
REQ-035 dbg write r1=5, r2=7; add r3,r1,r2 (0x00221820) -> done at N+3, done_rd=3, done_data=12, dbg read r3=12.
REQ-036 r1=0, r2=1; sub r4,r1,r2 -> done_data=0xFFFFFFFF; slt r5,r1,r2 -> 1; slt r5,r2,r1 -> 0.
REQ-037 r2=0x80000000; srl r6,r2 shamt=31 -> 1; add r0,r1,r2 -> done pulses, dbg read r0=0.
REQ-038 op=0x23 word, and funct=0x18 word -> illegal pulse next cycle, no done, all registers unchanged, instr_ready back next cycle.
REQ-039 dbg_we during EXEC to r7=9 -> r7 unchanged; dbg_we r1=3 with instruction accepted same cycle reading r1 -> result uses 3.
REQ-040 rst_n low in EXEC -> no done, registers 0, instr_ready=1 after release.
